conv2d_window_engine: RTL and testbench

//   Parametrised successor to the fixed 6x6 switch-loaded conv layer.
//   - Loads an IMG_N x IMG_N image one row per strobe edge.
//   - Latches a KER_K x KER_K signed kernel.
//   - Streams every valid-window dot product in raster order over a valid/ready handshake.
//   - Sits between the pad/switch row loader and the display/serial output stage.

---
 rtl/conv_pkg.sv | 21 ++
 rtl/conv2d_window_engine_if.sv | 39 +++
 rtl/conv_mac_window.sv | 42 ++++
 rtl/conv2d_window_engine.sv | 162 ++++++++++++++++
 tb/tb_conv2d_window_engine.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/conv_pkg.sv
// Shared definitions for conv2d_window_engine: FSM state encoding and width helpers.
package conv_pkg;

  typedef enum logic [1:0] {
    StLoad = 2'd0,
    StConv = 2'd1,
    StDone = 2'd2
  } state_e;

  // Accumulator width: pixel + coefficient product plus growth for K*K terms and a sign bit.
  function automatic int unsigned acc_w(int unsigned pix_w, int unsigned coef_w,
                                        int unsigned ker_k);
    return pix_w + coef_w + $clog2(ker_k * ker_k) + 1;
  endfunction

  // Index width that never collapses to zero bits.
  function automatic int unsigned idx_w(int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/conv2d_window_engine_if.sv
// Load/stream bus of conv2d_window_engine.
// master: row loader and output consumer. slave: the engine.
interface conv2d_window_engine_if #(
  parameter int unsigned IMG_N  = 6,
  parameter int unsigned PIX_W  = 1,
  parameter int unsigned KER_K  = 3,
  parameter int unsigned COEF_W = 4
) ();
  import conv_pkg::*;

  localparam int unsigned OUT_N = IMG_N - KER_K + 1;
  localparam int unsigned ACC_W = acc_w(PIX_W, COEF_W, KER_K);
  localparam int unsigned IDX_W = idx_w(OUT_N);
  localparam int unsigned ROW_W = idx_w(IMG_N + 1);

  logic                            clear;
  logic [IMG_N*PIX_W-1:0]          row_data;
  logic                            row_strobe;
  logic [KER_K*KER_K*COEF_W-1:0]   kernel_in;
  logic signed [ACC_W-1:0]         out_data;
  logic [IDX_W-1:0]                out_row;
  logic [IDX_W-1:0]                out_col;
  logic                            out_valid;
  logic                            out_ready;
  logic [ROW_W-1:0]                rows_loaded;
  logic                            busy;
  logic                            done;

  modport master (
    output clear, row_data, row_strobe, kernel_in, out_ready,
    input  out_data, out_row, out_col, out_valid, rows_loaded, busy, done
  );

  modport slave (
    input  clear, row_data, row_strobe, kernel_in, out_ready,
    output out_data, out_row, out_col, out_valid, rows_loaded, busy, done
  );

endinterface

// File: rtl/conv_mac_window.sv
// Combinational KxK dot product of the image window whose top-left corner is (row_i, col_i).
// Pixels are zero-extended, coefficients sign-extended to ACC_W.
module conv_mac_window #(
  parameter int unsigned IMG_N  = 6,
  parameter int unsigned PIX_W  = 1,
  parameter int unsigned KER_K  = 3,
  parameter int unsigned COEF_W = 4,
  parameter int unsigned ACC_W  = 10,
  parameter int unsigned IDX_W  = 2
) (
  input  logic [IMG_N*IMG_N*PIX_W-1:0]  img_i,
  input  logic [KER_K*KER_K*COEF_W-1:0] coef_i,
  input  logic [IDX_W-1:0]              row_i,
  input  logic [IDX_W-1:0]              col_i,
  output logic signed [ACC_W-1:0]       sum_o
);

  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  pix_ext;
  logic signed [ACC_W-1:0]  coef_ext;
  logic signed [COEF_W-1:0] coef_raw;

  // Sum of products over the window.
  always_comb begin
    acc      = '0;
    pix_ext  = '0;
    coef_ext = '0;
    coef_raw = '0;
    for (int unsigned i = 0; i < KER_K; i++) begin
      for (int unsigned j = 0; j < KER_K; j++) begin
        pix_ext = '0;
        pix_ext[PIX_W-1:0] = img_i[((row_i + i) * IMG_N + col_i + j) * PIX_W +: PIX_W];
        coef_raw = coef_i[(i * KER_K + j) * COEF_W +: COEF_W];
        coef_ext = ACC_W'(coef_raw);
        acc      = acc + pix_ext * coef_ext;
      end
    end
  end

  assign sum_o = acc;

endmodule

// File: rtl/conv2d_window_engine.sv
// Windowed 2-D convolution engine: loads an IMG_N x IMG_N image row by row, latches a KxK
// signed kernel, then streams every valid-window sum in raster order over valid/ready.
// Optional feature macro: RELU_EN (clamp negative sums to zero).
module conv2d_window_engine
  import conv_pkg::*;
#(
  parameter int unsigned IMG_N  = 6,
  parameter int unsigned PIX_W  = 1,
  parameter int unsigned KER_K  = 3,
  parameter int unsigned COEF_W = 4
) (
  input logic                   clk,
  input logic                   rst,
  conv2d_window_engine_if.slave bus
);

  localparam int unsigned OUT_N = IMG_N - KER_K + 1;
  localparam int unsigned ACC_W = acc_w(PIX_W, COEF_W, KER_K);
  localparam int unsigned IDX_W = idx_w(OUT_N);
  localparam int unsigned ROW_W = idx_w(IMG_N + 1);

  state_e                        state_q, state_d;
  logic                          strobe_q;
  logic [ROW_W-1:0]              rows_q, rows_d;
  logic [IDX_W-1:0]              row_q, row_d, col_q, col_d;
  logic                          valid_q, valid_d;
  logic signed [ACC_W-1:0]       data_q, data_d, sum;
  logic [IMG_N*IMG_N*PIX_W-1:0]  img_q;
  logic [KER_K*KER_K*COEF_W-1:0] coef_q;
  logic                          strobe_rise, row_we, coef_we, load_data, accept, last_beat;

  assign strobe_rise = bus.row_strobe & ~strobe_q;
  assign accept      = valid_q & bus.out_ready;
  assign last_beat   = (row_q == IDX_W'(OUT_N - 1)) && (col_q == IDX_W'(OUT_N - 1));

  // Window for the beat being registered next: the MAC sees the next-state index.
  conv_mac_window #(
    .IMG_N (IMG_N),
    .PIX_W (PIX_W),
    .KER_K (KER_K),
    .COEF_W(COEF_W),
    .ACC_W (ACC_W),
    .IDX_W (IDX_W)
  ) u_mac (
    .img_i (img_q),
    .coef_i(coef_q),
    .row_i (row_d),
    .col_i (col_d),
    .sum_o (sum)
  );

  // Next-state logic: row loading, raster stepping and the clear override.
  always_comb begin
    state_d   = state_q;
    rows_d    = rows_q;
    row_d     = row_q;
    col_d     = col_q;
    valid_d   = valid_q;
    data_d    = data_q;
    row_we    = 1'b0;
    coef_we   = 1'b0;
    load_data = 1'b0;
    unique case (state_q)
      StLoad: begin
        if (strobe_rise) begin
          row_we = 1'b1;
          rows_d = rows_q + 1'b1;
          if (rows_q == ROW_W'(IMG_N - 1)) begin
            state_d = StConv;
            coef_we = 1'b1;
            row_d   = '0;
            col_d   = '0;
            valid_d = 1'b0;
          end
        end
      end
      StConv: begin
        if (!valid_q) begin
          valid_d   = 1'b1;
          load_data = 1'b1;
        end else if (accept) begin
          if (last_beat) begin
            state_d = StDone;
            valid_d = 1'b0;
            rows_d  = '0;
          end else begin
            load_data = 1'b1;
            if (col_q == IDX_W'(OUT_N - 1)) begin
              col_d = '0;
              row_d = row_q + 1'b1;
            end else begin
              col_d = col_q + 1'b1;
            end
          end
        end
      end
      StDone: begin
        state_d = StLoad;
      end
      default: begin
        state_d = StLoad;
      end
    endcase

    if (bus.clear) begin
      state_d   = StLoad;
      rows_d    = '0;
      valid_d   = 1'b0;
      row_we    = 1'b0;
      coef_we   = 1'b0;
      load_data = 1'b0;
    end

    if (load_data) begin
`ifdef RELU_EN
      data_d = sum[ACC_W-1] ? '0 : sum;
`else
      data_d = sum;
`endif
    end
  end

  // Control and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StLoad;
      strobe_q <= 1'b0;
      rows_q   <= '0;
      row_q    <= '0;
      col_q    <= '0;
      valid_q  <= 1'b0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      strobe_q <= bus.row_strobe;
      rows_q   <= rows_d;
      row_q    <= row_d;
      col_q    <= col_d;
      valid_q  <= valid_d;
      data_q   <= data_d;
    end
  end

  // Image and coefficient storage; contents survive reset.
  always_ff @(posedge clk) begin
    if (row_we) begin
      img_q[rows_q * IMG_N * PIX_W +: IMG_N * PIX_W] <= bus.row_data;
    end
    if (coef_we) begin
      coef_q <= bus.kernel_in;
    end
  end

  assign bus.out_data    = data_q;
  assign bus.out_row     = row_q;
  assign bus.out_col     = col_q;
  assign bus.out_valid   = valid_q;
  assign bus.rows_loaded = rows_q;
  assign bus.busy        = (state_q == StConv);
  assign bus.done        = (state_q == StDone);

endmodule

// File: tb/tb_conv2d_window_engine.sv
// Self-checking bench for conv2d_window_engine against an arithmetic window-sum model.
module tb_conv2d_window_engine;

  localparam int IMG_N  = 6;
  localparam int PIX_W  = 1;
  localparam int KER_K  = 3;
  localparam int COEF_W = 4;
  localparam int OUT_N  = IMG_N - KER_K + 1;
  localparam int RW     = IMG_N * PIX_W;
  localparam int KW     = KER_K * KER_K * COEF_W;

  logic clk = 1'b0;
  logic rst = 1'b1;

  conv2d_window_engine_if #(
    .IMG_N(IMG_N), .PIX_W(PIX_W), .KER_K(KER_K), .COEF_W(COEF_W)
  ) bus ();

  conv2d_window_engine #(
    .IMG_N(IMG_N), .PIX_W(PIX_W), .KER_K(KER_K), .COEF_W(COEF_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int img[IMG_N][IMG_N];
  int ker[KER_K][KER_K];
  int got[OUT_N*OUT_N];

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int ref_out(int r, int c);
    int s = 0;
    for (int i = 0; i < KER_K; i++)
      for (int j = 0; j < KER_K; j++)
        s += img[r+i][c+j] * ker[i][j];
`ifdef RELU_EN
    if (s < 0) s = 0;
`endif
    return s;
  endfunction

  function automatic logic [RW-1:0] pack_row(int r);
    logic [RW-1:0] v = '0;
    for (int c = 0; c < IMG_N; c++) v[c*PIX_W +: PIX_W] = PIX_W'(img[r][c]);
    return v;
  endfunction

  function automatic logic [KW-1:0] pack_ker();
    logic [KW-1:0] v = '0;
    for (int i = 0; i < KER_K; i++)
      for (int j = 0; j < KER_K; j++)
        v[(i*KER_K+j)*COEF_W +: COEF_W] = COEF_W'(ker[i][j]);
    return v;
  endfunction

  task automatic set_random();
    for (int r = 0; r < IMG_N; r++)
      for (int c = 0; c < IMG_N; c++) img[r][c] = int'($urandom_range(0, (1 << PIX_W) - 1));
    for (int i = 0; i < KER_K; i++)
      for (int j = 0; j < KER_K; j++) ker[i][j] = int'($urandom_range(0, 15)) - 8;
  endtask

  // Strobe rows start..IMG_N-1 with one low cycle between edges; ends in the CONV entry cycle.
  task automatic load_image(input int start);
    bus.kernel_in = pack_ker();
    for (int r = start; r < IMG_N; r++) begin
      bus.row_data   = pack_row(r);
      bus.row_strobe = 1'b1;
      tick();
      check("rows_loaded", bus.rows_loaded, r + 1);
      bus.row_strobe = 1'b0;
      if (r != IMG_N - 1) tick();
    end
    check("busy_entry", bus.busy, 1);
  endtask

  // Drive a full stream from the CONV entry cycle, optionally stalling, clearing or injecting
  // strobe/kernel noise; every beat is compared with the model.
  task automatic run_stream(input int stall_beat, input int stall_len, input int clear_at,
                            input bit noise);
    int beat = 0;
    int stalled = 0;
    int cyc = 0;
    bus.out_ready = 1'b1;
    check("first_valid_delay", bus.out_valid, 0);
    tick();
    while (beat < OUT_N*OUT_N && cyc < 400) begin
      int er, ec;
      er = beat / OUT_N;
      ec = beat % OUT_N;
      check("beat_valid", bus.out_valid, 1);
      check("beat_row", bus.out_row, er);
      check("beat_col", bus.out_col, ec);
      check("beat_data", bus.out_data, ref_out(er, ec));
      check("done_low", bus.done, 0);
      check("busy_conv", bus.busy, 1);
      if (noise) check("rows_in_conv", bus.rows_loaded, IMG_N);
      got[beat] = bus.out_data;
      if (beat == clear_at) begin
        bus.clear     = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        bus.clear = 1'b0;
        check("clear_valid", bus.out_valid, 0);
        check("clear_busy", bus.busy, 0);
        check("clear_rows", bus.rows_loaded, 0);
        check("clear_done", bus.done, 0);
        tick();
        check("clear_no_done", bus.done, 0);
        check("clear_load", bus.busy, 0);
        return;
      end
      if (beat == stall_beat && stalled < stall_len) begin
        bus.out_ready = 1'b0;
        stalled++;
      end else begin
        bus.out_ready = 1'b1;
        beat++;
      end
      if (noise) begin
        bus.row_strobe = ~bus.row_strobe;
        bus.row_data   = RW'($urandom);
        bus.kernel_in  = KW'({$urandom, $urandom});
      end
      tick();
      cyc++;
    end
    check("stream_complete", beat, OUT_N*OUT_N);
    check("done_pulse", bus.done, 1);
    check("done_valid", bus.out_valid, 0);
    bus.row_strobe = 1'b0;
    tick();
    check("done_once", bus.done, 0);
    check("after_busy", bus.busy, 0);
    check("after_rows", bus.rows_loaded, 0);
  endtask

  initial begin
    bus.clear      = 1'b0;
    bus.row_strobe = 1'b0;
    bus.row_data   = '0;
    bus.kernel_in  = '0;
    bus.out_ready  = 1'b0;
    rst            = 1'b1;
    tick();
    check("rst_valid", bus.out_valid, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_rows", bus.rows_loaded, 0);
    check("rst_row", bus.out_row, 0);
    check("rst_col", bus.out_col, 0);
    check("rst_data", bus.out_data, 0);
    rst = 1'b0;
    tick();

    // All-ones image, all +1 kernel, continuous ready.
    for (int r = 0; r < IMG_N; r++) for (int c = 0; c < IMG_N; c++) img[r][c] = 1;
    for (int i = 0; i < KER_K; i++) for (int j = 0; j < KER_K; j++) ker[i][j] = 1;
    load_image(0);
    run_stream(-1, 0, -1, 1'b0);
    check("ones_first", got[0], 9);
    check("ones_last", got[OUT_N*OUT_N-1], 9);

    // Same load, 3-cycle stall at beat 5.
    load_image(0);
    run_stream(5, 3, -1, 1'b0);

    // Single pixel at (2,2), centre coefficient -8.
    for (int r = 0; r < IMG_N; r++) for (int c = 0; c < IMG_N; c++) img[r][c] = 0;
    img[2][2] = 1;
    ker[1][1] = -8;
    load_image(0);
    run_stream(-1, 0, -1, 1'b0);
`ifdef RELU_EN
    check("impulse_11", got[5], 0);
`else
    check("impulse_11", got[5], -8);
`endif
    check("impulse_00", got[0], 1);
    check("impulse_22", got[10], 1);
    check("impulse_33", got[15], 0);

    // Strobe held high writes one row; strobe/kernel noise during CONV is ignored.
    set_random();
    bus.row_data   = pack_row(0);
    bus.kernel_in  = pack_ker();
    bus.row_strobe = 1'b1;
    repeat (10) tick();
    check("held_strobe_rows", bus.rows_loaded, 1);
    bus.row_strobe = 1'b0;
    tick();
    load_image(1);
    run_stream(-1, 0, -1, 1'b1);

    // Clear coincident with an accept after 7 beats.
    set_random();
    load_image(0);
    run_stream(-1, 0, 7, 1'b0);

    // Asynchronous reset in the middle of CONV.
    set_random();
    load_image(0);
    bus.out_ready = 1'b1;
    repeat (3) tick();
    rst = 1'b1;
    #1;
    check("midrst_valid", bus.out_valid, 0);
    check("midrst_busy", bus.busy, 0);
    check("midrst_rows", bus.rows_loaded, 0);
    check("midrst_done", bus.done, 0);
    tick();
    rst = 1'b0;
    tick();
    check("postrst_busy", bus.busy, 0);
    check("postrst_rows", bus.rows_loaded, 0);
    bus.row_data   = pack_row(0);
    bus.row_strobe = 1'b1;
    tick();
    check("postrst_load", bus.rows_loaded, 1);
    bus.row_strobe = 1'b0;
    bus.clear      = 1'b1;
    tick();
    bus.clear = 1'b0;
    check("load_clear_rows", bus.rows_loaded, 0);

    // Random images and kernels with random stalls.
    for (int k = 0; k < 4; k++) begin
      set_random();
      load_image(0);
      run_stream(int'($urandom_range(0, OUT_N*OUT_N-1)), int'($urandom_range(1, 4)), -1, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
